alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU for the pipelined RISC-V core. It executes the legacy add/sub/and/or/slt operations plus xor, sltu, shifts and an iterative multiply, registers the result and the four status flags, and returns them with a pass-through tag. It sits between the decode/issue stage and writeback, so the execute stage can stall on a multi-cycle op or on a busy consumer.

---
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 tb/tb_alu_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle ops plus an iterative shift-add multiply,
// with one registered result slot carrying flags and a pass-through tag.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [TAG_W-1:0] out_tag,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [TAG_W-1:0] r_mtag;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_carry, r_ovf, r_zero, r_neg;

  logic             w_is_sub, w_is_mul, w_accept, w_load;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic [CW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_alu_res, w_mul_acc_nxt, w_res_d;
  logic             w_alu_c, w_alu_v, w_c_d, w_v_d;
  logic [TAG_W-1:0] w_tag_d;

  // SUB shares the adder: A + ~B + 1, so Carry=1 means no borrow.
  assign w_is_sub = (ALUControl == OP_SUB);
  assign w_is_mul = (ALUControl == OP_MUL);
  assign w_b_op   = w_is_sub ? ~B : B;
  assign w_sum    = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_shamt  = B[CW-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        // Same rule covers SUB because the effective second operand is ~B.
        w_alu_v   = (A[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  w_alu_res = A & B;
      OP_OR:   w_alu_res = A | B;
      OP_XOR:  w_alu_res = A ^ B;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  w_alu_res = A << w_shamt;
      OP_SRL:  w_alu_res = A >> w_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(A) >>> w_shamt);
      default: w_alu_res = '0;
    endcase
  end

  assign w_mul_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res_d     = w_alu_res;
    w_c_d       = w_alu_c;
    w_v_d       = w_alu_v;
    w_tag_d     = in_tag;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) w_state_nxt = S_MUL;
          else          w_load      = 1'b1;
        end
      end
      S_MUL: begin
        if (r_count == CNT_LAST) begin
          w_load      = 1'b1;
          w_res_d     = w_mul_acc_nxt;
          w_c_d       = 1'b0;
          w_v_d       = 1'b0;
          w_tag_d     = r_mtag;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_mtag      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_accept && w_is_mul) begin
        r_acc    <= '0;
        r_count  <= '0;
        r_mcand  <= A;
        r_mplier <= B;
        r_mtag   <= in_tag;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_mul_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res_d;
        r_out_tag   <= w_tag_d;
        r_carry     <= w_c_d;
        r_ovf       <= w_v_d;
        r_zero      <= (w_res_d == '0);
        r_neg       <= w_res_d[WIDTH-1];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign out_tag   = r_out_tag;
  assign Carry     = r_carry;
  assign OverFlow  = r_ovf;
  assign Zero      = r_zero;
  assign Negative  = r_neg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, Result;
  logic [3:0]    ALUControl;
  logic [TW-1:0] in_tag, out_tag;
  logic          Carry, OverFlow, Zero, Negative;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0]  r;
    logic [TW-1:0] t;
    logic [3:0]    f;
  } exp_t;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .out_tag(out_tag), .Carry(Carry), .OverFlow(OverFlow),
    .Zero(Zero), .Negative(Negative)
  );

  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] r, output logic c, v);
    longint sa, sb, s;
    logic [63:0] t;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin t = 64'(a) + 64'(b); r = t[W-1:0]; c = t[W]; s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      4'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 1 : 0;
      4'd6: r = (a < b) ? 1 : 0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = W'(sa >>> sh);
      4'd10: begin t = 64'(a) * 64'(b); r = t[W-1:0]; end
      default: r = '0;
    endcase
  endfunction

  function automatic exp_t ref_exp(input logic [3:0] op, input logic [W-1:0] a, b, input logic [TW-1:0] tag);
    exp_t e;
    logic [W-1:0] r;
    logic c, v;
    ref_alu(op, a, b, r, c, v);
    e.r = r; e.t = tag; e.f = {c, v, (r == '0), r[W-1]};
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Presents an op from a negedge and returns at the negedge after it is accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, input logic [TW-1:0] tag);
    int n;
    in_valid = 1'b1; ALUControl = op; A = a; B = b; in_tag = tag;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL issue_timeout op=%0d in_ready=%b want 1", op, in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, Result, out_tag, Carry, OverFlow, Zero, Negative} !== '0) begin
      errors++; $display("FAIL reset_outputs got ov=%b res=%h tag=%h want all 0", out_valid, Result, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy=%b ov=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd1);
    checks++;
    if (out_valid !== 1'b1 || Result !== 32'h8000_0000 || out_tag !== 5'd1 ||
        {Carry, OverFlow, Zero, Negative} !== 4'b0101) begin
      errors++; $display("FAIL add_ovf got ov=%b res=%h tag=%0d cvzn=%b%b%b%b want 1 80000000 1 0101",
                         out_valid, Result, out_tag, Carry, OverFlow, Zero, Negative);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got ov=%b want 0", out_valid); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    issue(4'd1, 32'd5, 32'd5, 5'd2);
    checks++;
    if (Result !== 32'd0 || {Carry, OverFlow, Zero, Negative} !== 4'b1010) begin
      errors++; $display("FAIL sub_eq got res=%h cvzn=%b%b%b%b want 0 1010", Result, Carry, OverFlow, Zero, Negative);
    end
    issue(4'd1, 32'd0, 32'd1, 5'd2);
    checks++;
    if (Result !== 32'hFFFF_FFFF || {Carry, OverFlow, Zero, Negative} !== 4'b0001) begin
      errors++; $display("FAIL sub_borrow got res=%h cvzn=%b%b%b%b want ffffffff 0001", Result, Carry, OverFlow, Zero, Negative);
    end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]   ops [5] = '{4'd9, 4'd7, 4'd5, 4'd6, 4'd15};
    logic [W-1:0] as  [5] = '{32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
    logic [W-1:0] bs  [5] = '{32'h3F, 32'h21, 32'd1, 32'd1, 32'h5678};
    logic [W-1:0] ex  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], TW'(i));
      checks++;
      if (Result !== ex[i] || Zero !== (ex[i] == '0) || Carry !== 1'b0 || OverFlow !== 1'b0) begin
        errors++; $display("FAIL shift_cmp[%0d] op=%0d got res=%h z=%b c=%b v=%b want %h z=%b c=0 v=0",
                           i, ops[i], Result, Zero, Carry, OverFlow, ex[i], (ex[i] == '0));
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd2, 5'd3);
    in_valid = 1'b1; ALUControl = 4'd4; A = 32'hF0; B = 32'hFF; in_tag = 5'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || Result !== 32'd3 || out_tag !== 5'd3) begin
        errors++; $display("FAIL stall_hold[%0d] got rdy=%b ov=%b res=%h tag=%0d want 0 1 3 3",
                           i, in_ready, out_valid, Result, out_tag);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Result !== 32'h0F || out_tag !== 5'd4) begin
      errors++; $display("FAIL stall_next got ov=%b res=%h tag=%0d want 1 0f 4", out_valid, Result, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got ov=%b want 0", out_valid); end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    in_valid = 1'b1; ALUControl = 4'd10; A = 32'hFFFF_FFFF; B = 32'd3; in_tag = 5'd7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept got rdy=%b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL mul_busy[%0d] got rdy=%b ov=%b want 0 0", i, in_ready, out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || Result !== 32'hFFFF_FFFD || out_tag !== 5'd7 ||
        {Carry, OverFlow, Zero, Negative} !== 4'b0001) begin
      errors++; $display("FAIL mul_result got ov=%b res=%h tag=%0d cvzn=%b%b%b%b want 1 fffffffd 7 0001",
                         out_valid, Result, out_tag, Carry, OverFlow, Zero, Negative);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'd10; A = $urandom | 32'h1; B = $urandom | 32'h1; in_tag = 5'd9;
    #1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, Result, out_tag, Carry, OverFlow, Zero, Negative} !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_mul got ov=%b res=%h tag=%h rdy=%b want 0 0 0 1", out_valid, Result, out_tag, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_mul_rdy got %b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_mul[%0d] got ov=%b want 0", i, out_valid); end
      @(negedge clk);
    end
    issue(4'd0, 32'd2, 32'd2, 5'd1);
    checks++;
    if (out_valid !== 1'b1 || Result !== 32'd4 || out_tag !== 5'd1) begin
      errors++; $display("FAIL post_reset_add got ov=%b res=%h tag=%0d want 1 4 1", out_valid, Result, out_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10) op = 4'd11;
      in_valid = 1'b1; ALUControl = op; A = rand_operand(); B = rand_operand(); in_tag = TW'($urandom);
      e = ref_exp(op, A, B, in_tag);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b want 1", i, in_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {Result, out_tag, Carry, OverFlow, Zero, Negative} !== e) begin
        errors++; $display("FAIL b2b[%0d] op=%0d got ov=%b %h/%0d/%b%b%b%b want %h/%0d/%b",
                           i, op, out_valid, Result, out_tag, Carry, OverFlow, Zero, Negative, e.r, e.t, e.f);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_bp();
    exp_t q[$];
    exp_t e;
    int busy;
    logic exp_ov, exp_rdy;
    logic [3:0] op;
    busy = 0;
    for (int i = 0; i < 340; i++) begin
      if (busy > 0) busy--;
      op = ($urandom_range(0, 15) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      ALUControl = op; A = rand_operand(); B = rand_operand(); in_tag = TW'($urandom);
      if (i < 300) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_ov  = (busy == 0) && (q.size() > 0);
      exp_rdy = (busy == 0) && (!exp_ov || out_ready);
      checks++;
      if (out_valid !== exp_ov || in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_hs[%0d] got ov=%b rdy=%b want %b %b", i, out_valid, in_ready, exp_ov, exp_rdy);
      end
      if (exp_ov && out_ready) begin
        e = q.pop_front();
        checks++;
        if ({Result, out_tag, Carry, OverFlow, Zero, Negative} !== e) begin
          errors++; $display("FAIL rand_data[%0d] got %h/%0d/%b%b%b%b want %h/%0d/%b",
                             i, Result, out_tag, Carry, OverFlow, Zero, Negative, e.r, e.t, e.f);
        end
      end
      if (in_valid && exp_rdy) begin
        q.push_back(ref_exp(op, A, B, in_tag));
        if (op == 4'd10) busy = W + 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d pending want 0", q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; ALUControl = '0; A = '0; B = '0; in_tag = '0;
    test_reset();
    test_add();
    test_sub();
    test_shift_cmp();
    test_stall();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    test_random_bp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
